vga_timing_pipeline: RTL and testbench

Parametrised next-generation display controller core. Generates pixel-clock enable, horizontal/vertical counters and sync pulses for any VGA-style timing. Issues pixel coordinates to an external renderer and accepts its colour a fixed number of pixel ticks later. Delays sync and blank to stay aligned with the colour, then registers all pin outputs. Sits between the system clock domain and the VGA connector, replacing the fixed 640x480, divide-by-2 arrangement.

---
 rtl/vga_timing_pkg.sv | 58 +++++
 rtl/vga_timing_pipeline_if.sv | 59 +++++
 rtl/vga_ctrl_delay.sv | 47 ++++
 rtl/vga_timing_pipeline.sv | 163 ++++++++++++++++
 tb/tb_vga_timing_pipeline.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing helpers and the {hs,vs,blank} control bundle used by the
// VGA timing core and its alignment delay line.
package vga_timing_pkg;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } ctrl_t;

  localparam int unsigned CTRL_W = 3;

  function automatic int unsigned calc_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_start(
    input int unsigned active,
    input int unsigned fp
  );
    return active + fp;
  endfunction

  function automatic int unsigned sync_end(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync
  );
    return active + fp + sync;
  endfunction

  // True when value is representable in an unsigned field of the given width.
  function automatic bit fits_width(
    input int unsigned value,
    input int unsigned width
  );
    longint unsigned limit;
    limit = 64'd1 << width;
    return (64'(value) < limit);
  endfunction

  function automatic ctrl_t idle_ctrl(
    input logic hs_pol,
    input logic vs_pol
  );
    ctrl_t c;
    c.hs    = ~hs_pol;
    c.vs    = ~vs_pol;
    c.blank = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_pipeline_if.sv
// Bundle of renderer-side and connector-side signals of the VGA timing core.
interface vga_timing_pipeline_if #(
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned COORD_W = 11
);

  logic               en;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pix_valid;
  logic               pix_ce;
  logic               frame_start;
  logic [COLOR_W-1:0] r_in;
  logic [COLOR_W-1:0] g_in;
  logic [COLOR_W-1:0] b_in;
  logic               hs;
  logic               vs;
  logic               blank;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;

  modport master (
    input  en,
    input  r_in,
    input  g_in,
    input  b_in,
    output x,
    output y,
    output pix_valid,
    output pix_ce,
    output frame_start,
    output hs,
    output vs,
    output blank,
    output r,
    output g,
    output b
  );

  modport slave (
    output en,
    output r_in,
    output g_in,
    output b_in,
    input  x,
    input  y,
    input  pix_valid,
    input  pix_ce,
    input  frame_start,
    input  hs,
    input  vs,
    input  blank,
    input  r,
    input  g,
    input  b
  );

endinterface

// File: rtl/vga_ctrl_delay.sv
// Clock-enabled shift register that delays the {hs,vs,blank} bundle by DEPTH
// pixel ticks; DEPTH 0 is a straight pass-through.
module vga_ctrl_delay
  import vga_timing_pkg::*;
#(
  parameter int    DEPTH = 1,
  parameter ctrl_t IDLE  = ctrl_t'(3'b111)
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  ce,
  input  ctrl_t din,
  output ctrl_t dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_s;
      assign unused_s = ^{clk, rst, clr, ce};
      assign dout     = din;
    end else begin : g_shift
      ctrl_t stage_r [DEPTH];

      // Shift on each pixel tick; a synchronous clear returns every stage to idle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= IDLE;
          end
        end else if (clr) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= IDLE;
          end
        end else if (ce) begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pipeline.sv
// VGA timing core: pixel-tick divider, h/v counters, sync generation and a
// renderer-aligned control delay feeding registered connector outputs.
module vga_timing_pipeline
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned RENDER_LAT = 1
) (
  input logic                   clk,
  input logic                   rst,
  vga_timing_pipeline_if.master bus
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  localparam ctrl_t              IDLE_CTRL = idle_ctrl(HS_POL, VS_POL);

  generate
    if (!fits_width(H_TOTAL - 1, COORD_W) || !fits_width(V_TOTAL - 1, COORD_W)) begin : g_bad_coord
      $error("vga_timing_pipeline: H_TOTAL-1 or V_TOTAL-1 does not fit COORD_W");
    end
    if (CLK_DIV < 1 || RENDER_LAT > 7) begin : g_bad_param
      $error("vga_timing_pipeline: CLK_DIV must be >= 1 and RENDER_LAT in 0..7");
    end
  endgenerate

  logic               run_r;
  logic [DIV_W-1:0]   div_r;
  logic [COORD_W-1:0] h_cnt_r;
  logic [COORD_W-1:0] v_cnt_r;
  logic               pix_ce_s;
  logic               pix_valid_s;
  logic               hs_act_s;
  logic               vs_act_s;
  ctrl_t              ctrl_raw_s;
  ctrl_t              ctrl_dly_s;
  logic               hs_r;
  logic               vs_r;
  logic               blank_r;
  logic [COLOR_W-1:0] r_r;
  logic [COLOR_W-1:0] g_r;
  logic [COLOR_W-1:0] b_r;

  // run_r lags en by one clk so the divider restarts cleanly after enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_r <= 1'b0;
      div_r <= {DIV_W{1'b0}};
    end else if (!bus.en) begin
      run_r <= 1'b0;
      div_r <= {DIV_W{1'b0}};
    end else begin
      run_r <= 1'b1;
      if (run_r) begin
        div_r <= (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
      end
    end
  end

  assign pix_ce_s = run_r & (div_r == DIV_LAST);

  // Horizontal/vertical position counters, advanced once per pixel tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= {COORD_W{1'b0}};
      v_cnt_r <= {COORD_W{1'b0}};
    end else if (!bus.en) begin
      h_cnt_r <= {COORD_W{1'b0}};
      v_cnt_r <= {COORD_W{1'b0}};
    end else if (pix_ce_s) begin
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= {COORD_W{1'b0}};
        v_cnt_r <= (v_cnt_r == V_LAST) ? {COORD_W{1'b0}} : v_cnt_r + COORD_W'(1);
      end else begin
        h_cnt_r <= h_cnt_r + COORD_W'(1);
      end
    end
  end

  // Undelayed control bundle for the coordinate currently being issued.
  always_comb begin
    pix_valid_s      = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    hs_act_s         = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    vs_act_s         = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    ctrl_raw_s.hs    = hs_act_s ? HS_POL : ~HS_POL;
    ctrl_raw_s.vs    = vs_act_s ? VS_POL : ~VS_POL;
    ctrl_raw_s.blank = ~pix_valid_s;
  end

  vga_ctrl_delay #(
    .DEPTH (int'(RENDER_LAT)),
    .IDLE  (IDLE_CTRL)
  ) u_ctrl_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (~bus.en),
    .ce   (pix_ce_s),
    .din  (ctrl_raw_s),
    .dout (ctrl_dly_s)
  );

  // Pin register: control and colour land together, colour forced dark while blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_r    <= ~HS_POL;
      vs_r    <= ~VS_POL;
      blank_r <= 1'b1;
      r_r     <= {COLOR_W{1'b0}};
      g_r     <= {COLOR_W{1'b0}};
      b_r     <= {COLOR_W{1'b0}};
    end else if (!run_r) begin
      hs_r    <= ~HS_POL;
      vs_r    <= ~VS_POL;
      blank_r <= 1'b1;
      r_r     <= {COLOR_W{1'b0}};
      g_r     <= {COLOR_W{1'b0}};
      b_r     <= {COLOR_W{1'b0}};
    end else if (pix_ce_s) begin
      hs_r    <= ctrl_dly_s.hs;
      vs_r    <= ctrl_dly_s.vs;
      blank_r <= ctrl_dly_s.blank;
      r_r     <= ctrl_dly_s.blank ? {COLOR_W{1'b0}} : bus.r_in;
      g_r     <= ctrl_dly_s.blank ? {COLOR_W{1'b0}} : bus.g_in;
      b_r     <= ctrl_dly_s.blank ? {COLOR_W{1'b0}} : bus.b_in;
    end
  end

  assign bus.x           = h_cnt_r;
  assign bus.y           = v_cnt_r;
  assign bus.pix_valid   = pix_valid_s;
  assign bus.pix_ce      = pix_ce_s;
  assign bus.frame_start = pix_ce_s & (h_cnt_r == {COORD_W{1'b0}}) & (v_cnt_r == {COORD_W{1'b0}});
  assign bus.hs          = hs_r;
  assign bus.vs          = vs_r;
  assign bus.blank       = blank_r;
  assign bus.r           = r_r;
  assign bus.g           = g_r;
  assign bus.b           = b_r;

endmodule

// File: tb/tb_vga_timing_pipeline.sv
// Directed bench for vga_timing_pipeline on a tiny 8x6 raster with a
// scoreboard of expected pin values and a cycle-level reference model.
module tb_vga_timing_pipeline;

  localparam logic [11:0] IDLE_PINS = 12'b111_000_000_000;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  logic en_v = 1'b1;
  logic [2:0] rin = 3'd0;
  logic [2:0] gin = 3'd0;
  logic [2:0] bin = 3'd0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  vga_timing_pipeline_if #(.COLOR_W(3), .COORD_W(11)) bus1 ();
  vga_timing_pipeline_if #(.COLOR_W(3), .COORD_W(11)) bus2 ();

  assign bus1.en = en_v;
  assign bus1.r_in = rin;
  assign bus1.g_in = gin;
  assign bus1.b_in = bin;
  assign bus2.en = en_v;
  assign bus2.r_in = rin;
  assign bus2.g_in = gin;
  assign bus2.b_in = bin;

  vga_timing_pipeline #(
    .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(3), .COORD_W(11), .RENDER_LAT(1)
  ) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  vga_timing_pipeline #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(3), .COORD_W(11), .RENDER_LAT(0)
  ) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  logic [10:0] obs_x, obs_y;
  logic        obs_valid, obs_ce, obs_fs;
  logic [11:0] obs_pins;

  always_comb begin
    if (sel) begin
      obs_x = bus2.x; obs_y = bus2.y; obs_valid = bus2.pix_valid;
      obs_ce = bus2.pix_ce; obs_fs = bus2.frame_start;
      obs_pins = {bus2.hs, bus2.vs, bus2.blank, bus2.r, bus2.g, bus2.b};
    end else begin
      obs_x = bus1.x; obs_y = bus1.y; obs_valid = bus1.pix_valid;
      obs_ce = bus1.pix_ce; obs_fs = bus1.frame_start;
      obs_pins = {bus1.hs, bus1.vs, bus1.blank, bus1.r, bus1.g, bus1.b};
    end
  end

  int total = 0;
  int bad = 0;

  // Reference model state for the currently selected DUT.
  int div_n = 2;
  int lat = 1;
  int m_div, m_h, m_v;
  bit m_run;
  int pin_skip = 0;
  int fs_cnt = 0;
  int ce_cnt = 0;
  logic [11:0] exp_pins;
  logic [11:0] pin_q[$];
  int hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected connector word for pixel (h,v): sync active-low, colour r=h g=7-h b=v.
  function automatic logic [11:0] pin_word(input int h, input int v);
    logic hs, vs, blank;
    logic [2:0] r, g, b;
    hs = !(h >= 5 && h < 7);
    vs = !(v == 4);
    blank = !(h < 4 && v < 3);
    r = blank ? 3'd0 : 3'(h);
    g = blank ? 3'd0 : 3'(7 - h);
    b = blank ? 3'd0 : 3'(v);
    return {hs, vs, blank, r, g, b};
  endfunction

  task automatic model_reset();
    m_div = 0; m_h = 0; m_v = 0; m_run = 1'b0;
    pin_q.delete();
    for (int i = 0; i < lat; i++) pin_q.push_back(IDLE_PINS);
    exp_pins = IDLE_PINS;
    hist.delete();
    hist.push_back(0);
  endtask

  task automatic step();
    bit tick;
    int idx;
    @(posedge clk);
    if (sel ? rst2 : rst1) begin
      model_reset();
    end else if (!en_v) begin
      if (m_run) pin_skip = 1;
      model_reset();
    end else begin
      tick = m_run && (m_div == div_n - 1);
      if (m_run) m_div = (m_div == div_n - 1) ? 0 : m_div + 1;
      m_run = 1'b1;
      if (tick) begin
        pin_q.push_back(pin_word(m_h, m_v));
        exp_pins = pin_q.pop_front();
        if (m_h == 7) begin
          m_h = 0;
          m_v = (m_v == 5) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
        hist.push_back(m_h * 8 + m_v);
      end
    end
    #1;
    idx = hist.size() - 1 - lat;
    if (idx >= 0) begin
      rin = 3'(hist[idx] / 8);
      gin = 3'(7 - hist[idx] / 8);
      bin = 3'(hist[idx] % 8);
    end else begin
      rin = 3'd0; gin = 3'd0; bin = 3'd0;
    end
    if (obs_fs) fs_cnt++;
    if (obs_ce) ce_cnt++;
    check("x", 32'(obs_x), 32'(m_h));
    check("y", 32'(obs_y), 32'(m_v));
    check("pix_valid", 32'(obs_valid), 32'(m_h < 4 && m_v < 3));
    check("pix_ce", 32'(obs_ce), 32'(m_run && m_div == div_n - 1));
    check("frame_start", 32'(obs_fs), 32'(m_run && m_div == div_n - 1 && m_h == 0 && m_v == 0));
    if (pin_skip > 0) pin_skip--;
    else check("pins", 32'(obs_pins), 32'(exp_pins));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset held for 5 clocks, then released between edges.
    repeat (5) step();
    check("rst_pins", 32'(obs_pins), 32'(IDLE_PINS));
    @(negedge clk);
    rst1 = 1'b0;
    step();
    check("first_ce_clk1", 32'(obs_ce), 32'd0);
    step();
    check("first_ce_clk2", 32'(obs_ce), 32'd1);
    check("first_fs_clk2", 32'(obs_fs), 32'd1);

    // Two full frames of free running.
    fs_cnt = 0; ce_cnt = 0;
    repeat (192) step();
    check("frames_in_192clk", 32'(fs_cnt), 32'd2);
    check("ticks_in_192clk", 32'(ce_cnt), 32'd96);

    // Drop en at x=3,y=1 for 4 clocks.
    for (int i = 0; i < 200 && !(m_h == 3 && m_v == 1); i++) step();
    check("reach_x", 32'(obs_x), 32'd3);
    check("reach_y", 32'(obs_y), 32'd1);
    en_v = 1'b0;
    repeat (4) step();
    check("en_off_pins", 32'(obs_pins), 32'(IDLE_PINS));
    check("en_off_x", 32'(obs_x), 32'd0);
    en_v = 1'b1;
    step();
    check("en_on_ce1", 32'(obs_ce), 32'd0);
    step();
    check("en_on_ce2", 32'(obs_ce), 32'd1);
    check("en_on_fs", 32'(obs_fs), 32'd1);
    repeat (96) step();

    // Asynchronous reset between edges while an active pixel is on the pins.
    for (int i = 0; i < 200 && exp_pins[9] != 1'b0; i++) step();
    check("pre_rst_blank", 32'(obs_pins[9]), 32'd0);
    #2;
    rst1 = 1'b1;
    #1;
    check("async_rst_pins", 32'(obs_pins), 32'(IDLE_PINS));
    check("async_rst_ce", 32'(obs_ce), 32'd0);
    check("async_rst_x", 32'(obs_x), 32'd0);
    model_reset();
    pin_skip = 0;
    repeat (3) step();

    // Second configuration: CLK_DIV=1, RENDER_LAT=0.
    sel = 1'b1; div_n = 1; lat = 0;
    model_reset();
    repeat (2) step();
    @(negedge clk);
    rst2 = 1'b0;
    step();
    check("div1_first_ce", 32'(obs_ce), 32'd1);
    check("div1_first_fs", 32'(obs_fs), 32'd1);
    fs_cnt = 0; ce_cnt = 0;
    repeat (96) step();
    check("div1_frames", 32'(fs_cnt), 32'd2);
    check("div1_ticks", 32'(ce_cnt), 32'd96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
